matrix_load_sequencer: RTL and testbench

- Initiator side of the matrix-core memory request/response protocol.
- Takes one load command (LOAD_W, LOAD_X or READ_ACC) and issues the matching run of element reads to the SRAM memory responder.
- Collects the returned words and streams them in order to the matrix core with a last marker.
- Credit-limits outstanding reads so the response path never back-pressures the memory.

---
 rtl/matrix_load_sequencer_if.sv | 28 ++
 rtl/matrix_load_sequencer.sv | 173 +++++++++++++++++
 tb/tb_matrix_load_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_load_sequencer_if.sv
// Memory request/response and element-stream signals of the matrix load sequencer.
// master = sequencer side, slave = memory responder / matrix core side.
interface matrix_load_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  req_vld;
    logic                  req_rdy;
    logic [1:0]            req_cfg;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  out_vld;
    logic                  out_rdy;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output req_vld, req_cfg, req_addr, rsp_rdy, out_vld, out_data, out_last,
        input  req_rdy, rsp_vld, rsp_data, out_rdy
    );

    modport slave (
        input  req_vld, req_cfg, req_addr, rsp_rdy, out_vld, out_data, out_last,
        output req_rdy, rsp_vld, rsp_data, out_rdy
    );
endinterface

// File: rtl/matrix_load_sequencer.sv
// Issues credit-limited element reads for one load command and streams the responses in order.
// Optional macro MLS_STALL_CNT_EN builds a saturating request-stall counter on stall_cycles.
module matrix_load_sequencer #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned MAT_DIM         = 4,
    parameter int unsigned X_DEPTH         = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_start,
    input  logic [1:0]            cmd_cfg,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           stall_cycles,
    matrix_load_sequencer_if.master bus
);

    localparam int unsigned WTotal   = MAT_DIM * MAT_DIM;
    localparam int unsigned MaxTotal = (WTotal > X_DEPTH) ? WTotal : X_DEPTH;
    localparam int unsigned CntW     = $clog2(MaxTotal + 1);
    localparam int unsigned OcW      = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PtrW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [1:0]  CfgIllegal = 2'd3;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [1:0]            cfg_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CntW-1:0]       issue_cnt_q, out_cnt_q;
    logic [CntW-1:0]       total, total_m1;
    logic [OcW-1:0]        inflight_q, inflight_d;
    logic [OcW-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [MAX_OUTSTANDING];
    logic                  err_q;

    logic accept, credit_ok, req_vld_c, req_fire, push, pop, rsp_bad, out_vld_c;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        case (cfg_q)
            2'd0:    total = CntW'(WTotal);
            default: total = CntW'(X_DEPTH);
        endcase
        total_m1 = total - CntW'(1);
    end

    // Buffered responses hold credits too, so the FIFO can never overflow.
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < (OcW + 1)'(MAX_OUTSTANDING);

    assign req_fire  = req_vld_c && bus.req_rdy;
    assign push      = bus.rsp_vld && (state_q != StIdle) && (inflight_q != '0);
    assign rsp_bad   = bus.rsp_vld && !push;
    assign out_vld_c = (fifo_cnt_q != '0);
    assign pop       = out_vld_c && bus.out_rdy;

    assign bus.req_vld  = req_vld_c;
    assign bus.req_cfg  = cfg_q;
    assign bus.req_addr = base_q + ADDR_WIDTH'(issue_cnt_q);
    assign bus.rsp_rdy  = 1'b1;
    assign bus.out_vld  = out_vld_c;
    assign bus.out_data = mem_q[rd_ptr_q];
    assign bus.out_last = out_vld_c && (out_cnt_q == total_m1);
    assign err          = err_q;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        req_vld_c = 1'b0;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        unique case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    accept  = 1'b1;
                    state_d = (cmd_cfg == CfgIllegal) ? StDone : StIssue;
                end
            end
            StIssue: begin
                req_vld_c = (issue_cnt_q < total) && credit_ok;
                if (req_vld_c && bus.req_rdy && (issue_cnt_q == total_m1)) state_d = StDrain;
            end
            StDrain: begin
                if (pop && (out_cnt_q == total_m1)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({req_fire, push})
            2'b10:   inflight_d = inflight_q + OcW'(1);
            2'b01:   inflight_d = inflight_q - OcW'(1);
            default: inflight_d = inflight_q;
        endcase
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + OcW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - OcW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q       <= '0;
            base_q      <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) mem_q[i] <= '0;
        end else begin
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (accept) begin
                if (cmd_cfg != CfgIllegal) begin
                    cfg_q  <= cmd_cfg;
                    base_q <= cmd_base;
                end
                issue_cnt_q <= '0;
                out_cnt_q   <= '0;
                err_q       <= (cmd_cfg == CfgIllegal) || rsp_bad;
            end else begin
                if (req_fire) issue_cnt_q <= issue_cnt_q + CntW'(1);
                if (pop)      out_cnt_q   <= out_cnt_q + CntW'(1);
                if (rsp_bad)  err_q       <= 1'b1;
            end
            if (push) begin
                mem_q[wr_ptr_q] <= bus.rsp_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

`ifdef MLS_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if (req_vld_c && !bus.req_rdy && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Scoreboard bench for matrix_load_sequencer: expected requests/elements are queued at stimulus
// time and popped by independent monitors; a 1-cycle memory model returns addr ^ 8'h5A.
module tb_matrix_load_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;
`ifdef MLS_STALL_CNT_EN
    localparam int ExpStall = 3;
`else
    localparam int ExpStall = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic [1:0]  cmd_cfg = 2'd0;
    logic [7:0]  cmd_base = 8'd0;
    logic        busy, done, err;
    logic [15:0] stall_cycles;
    logic        inject = 1'b0;

    matrix_load_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    matrix_load_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAT_DIM(4), .X_DEPTH(4), .MAX_OUTSTANDING(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_start   (cmd_start),
        .cmd_cfg     (cmd_cfg),
        .cmd_base    (cmd_base),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .stall_cycles(stall_cycles),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_vld_cyc = -1;
    int last_pop_cyc = -1;
    int req_count = 0;
    int done_count = 0;

    logic [9:0] req_q[$];  // {cfg, addr}
    logic [8:0] out_q[$];  // {last, data}

    always @(posedge clk) cyc <= cyc + 1;

    // 1-cycle memory; inject forces a stray response
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_vld  <= 1'b0;
            bus.rsp_data <= '0;
        end else begin
            bus.rsp_vld  <= (bus.req_vld && bus.req_rdy) || inject;
            bus.rsp_data <= bus.req_addr ^ 8'h5A;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Request monitor: also checks address/cfg stability while stalled
    always @(negedge clk) begin
        if (rst_n && bus.req_vld) begin
            check("req_expected", 32'(req_q.size() != 0), 1);
            if (req_q.size() != 0) begin
                check("req_cfg_addr", {22'd0, bus.req_cfg, bus.req_addr}, {22'd0, req_q[0]});
                if (bus.req_rdy) begin
                    void'(req_q.pop_front());
                    req_count++;
                end
            end
        end
    end

    // Output monitor
    always @(negedge clk) begin
        if (rst_n && bus.out_vld) begin
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
            if (bus.out_rdy) begin
                check("out_expected", 32'(out_q.size() != 0), 1);
                if (out_q.size() != 0) begin
                    check("out_last_data", {23'd0, bus.out_last, bus.out_data},
                          {23'd0, out_q.pop_front()});
                end
                if (bus.out_last) last_pop_cyc = cyc;
            end
        end
    end

    always @(negedge clk) if (rst_n && done) done_count++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] cfg, input logic [7:0] base);
        int n;
        logic [7:0] a;
        logic [8:0] e;
        n = (cfg == 2'd0) ? 16 : 4;
        for (int i = 0; i < n; i++) begin
            a = base + 8'(i);
            req_q.push_back({cfg, a});
            e = {(i == n - 1), a ^ 8'h5A};
            out_q.push_back(e);
        end
    endtask

    // Called just after a rising edge; returns one cycle later with cmd_start low
    task automatic start(input logic [1:0] cfg, input logic [7:0] base);
        cmd_cfg = cfg;
        cmd_base = base;
        cmd_start = 1'b1;
        start_cyc = cyc;
        first_vld_cyc = -1;
        tick(1);
        cmd_start = 1'b0;
    endtask

    // Leaves the bench at the falling edge of the done cycle
    task automatic wait_done(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_seen", 32'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0;
        bus.req_rdy = 1'b1;
        bus.out_rdy = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_ctrl", {29'd0, busy, done, err}, 0);
        check("rst_bus", {29'd0, bus.req_vld, bus.out_vld, bus.out_last}, 0);
        check("rst_rsp_rdy", 32'(bus.rsp_rdy), 1);
        check("rst_stall", 32'(stall_cycles), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1);

        // LOAD_W, base 0x10
        push_exp(2'd0, 8'h10);
        start(2'd0, 8'h10);
        check("busy_after_start", 32'(busy), 1);
        wait_done(200);
        check("w_err", 32'(err), 0);
        check("w_done_after_last_pop", 32'(cyc - last_pop_cyc), 1);
        check("w_first_out_latency", 32'(first_vld_cyc - start_cyc), 3);
        check("w_queues_empty", 32'(req_q.size() + out_q.size()), 0);
        check("w_stall", 32'(stall_cycles), 0);
        tick(1);
        check("w_done_one_cycle", {30'd0, done, busy}, 0);

        // LOAD_X with address wrap
        push_exp(2'd1, 8'hFE);
        start(2'd1, 8'hFE);
        wait_done(100);
        check("x_err", 32'(err), 0);
        check("x_queues_empty", 32'(req_q.size() + out_q.size()), 0);
        tick(1);

        // READ_ACC with consumer stalled: credits cap requests at 2
        bus.out_rdy = 1'b0;
        push_exp(2'd2, 8'h33);
        req_count = 0;
        start(2'd2, 8'h33);
        tick(9);
        check("acc_credit_reqs", 32'(req_count), 2);
        check("acc_req_vld_low", 32'(bus.req_vld), 0);
        check("acc_fifo_full_vld", 32'(bus.out_vld), 1);
        bus.out_rdy = 1'b1;
        wait_done(100);
        check("acc_total_reqs", 32'(req_count), 4);
        check("acc_queues_empty", 32'(req_q.size() + out_q.size()), 0);
        tick(1);

        // Stray response in IDLE is dropped and flags err
        inject = 1'b1;
        tick(1);
        inject = 1'b0;
        tick(1);
        check("stray_err", 32'(err), 1);
        check("stray_no_out", 32'(bus.out_vld), 0);
        tick(1);

        // Illegal cfg
        start(2'd3, 8'h00);
        wait_done(10);
        check("ill_err", 32'(err), 1);
        check("ill_done_timing", 32'((cyc - start_cyc >= 1) && (cyc - start_cyc <= 2)), 1);
        tick(1);
        check("ill_err_sticky", {30'd0, err, busy}, 2);
        push_exp(2'd1, 8'h40);
        start(2'd1, 8'h40);
        check("err_cleared_on_start", 32'(err), 0);
        wait_done(100);
        check("x40_queues_empty", 32'(req_q.size() + out_q.size()), 0);
        tick(1);

        // Reset mid-LOAD_W after 5 requests
        push_exp(2'd0, 8'h80);
        req_count = 0;
        dc0 = done_count;
        start(2'd0, 8'h80);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            if (req_count == 5) break;
        end
        check("mid_reqs_before_rst", 32'(req_count), 5);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", {29'd0, busy, done, err}, 0);
        check("mid_rst_bus", {21'd0, bus.req_vld, bus.out_vld, bus.out_last, bus.out_data}, 0);
        check("mid_rst_rsp_rdy", 32'(bus.rsp_rdy), 1);
        req_q.delete();
        out_q.delete();
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check("mid_no_done", 32'(done_count - dc0), 0);
        check("mid_idle", {30'd0, busy, err}, 0);
        push_exp(2'd1, 8'h20);
        start(2'd1, 8'h20);
        wait_done(100);
        check("post_rst_err", 32'(err), 0);
        check("post_rst_queues_empty", 32'(req_q.size() + out_q.size()), 0);
        tick(1);

        // Three stalled cycles on the first request
        bus.req_rdy = 1'b0;
        push_exp(2'd1, 8'h60);
        start(2'd1, 8'h60);
        tick(3);
        bus.req_rdy = 1'b1;
        wait_done(100);
        check("stall_cycles", 32'(stall_cycles), 32'(ExpStall));
        check("stall_queues_empty", 32'(req_q.size() + out_q.size()), 0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
